// File: rtl/ter_poly_ctrl.sv
// ter_poly_ctrl: streams two ternary polynomials through a coefficient-wise
// add/sub/mul/neg unit into a result sink with backpressure.
module ter_poly_ctrl #(
    parameter int N  = 701,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [1:0]    a_data,
    input  logic [1:0]    b_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [1:0]    wr_data,
    input  logic          wr_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    state_t        state, state_nx;
    logic [1:0]    op_q;
    logic [AW-1:0] idx;
    logic          rd_vld;
    logic [AW-1:0] rd_tag;
    logic          skid_vld;
    logic [AW-1:0] skid_addr;
    logic [1:0]    skid_data;
    logic          stall;
    logic          last_wr;
    logic          bad;
    logic [1:0]    x, y;
    logic [1:0]    res;

    // Internal value domain: 0, 1, 2 (= -1); the invalid code maps to 0.
    function automatic logic [1:0] dec(input logic [1:0] c);
        case (c)
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] enc(input logic [1:0] v);
        case (v)
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] neg3(input logic [1:0] v);
        case (v)
            2'd1:    return 2'd2;
            2'd2:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] red3(input logic [2:0] s);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    assign stall   = wr_en & ~wr_ready;
    assign rd_en   = (state == RUN) & ~stall;
    assign rd_addr = rd_en ? idx : '0;
    assign busy    = (state == RUN) | (state == DRAIN);
    assign done    = (state == DONE);
    assign last_wr = wr_en & wr_ready & (wr_addr == LAST);

    always_comb begin
        x   = dec(a_data);
        y   = dec(b_data);
        bad = (a_data == 2'b10) | ((b_data == 2'b10) & (op_q != 2'b11));
        case (op_q)
            OP_ADD:  res = enc(red3({1'b0, x} + {1'b0, y}));
            OP_SUB:  res = enc(red3({1'b0, x} + {1'b0, neg3(y)}));
            OP_MUL:  res = enc(red3({1'b0, x} * {1'b0, y}));
            default: res = enc(neg3(x));
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (rd_en && idx == LAST) state_nx = DRAIN;
            DRAIN: if (last_wr) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= '0;
            err       <= 1'b0;
            idx       <= '0;
            rd_vld    <= 1'b0;
            rd_tag    <= '0;
            skid_vld  <= 1'b0;
            skid_addr <= '0;
            skid_data <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state  <= state_nx;
            rd_vld <= rd_en;
            rd_tag <= rd_addr;
            if (state == IDLE && start) begin
                op_q <= op;
                err  <= 1'b0;
                idx  <= '0;
            end else if (rd_en) begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            if (rd_vld && bad) err <= 1'b1;
            // Output stage advances unless the sink holds it; the skid
            // slot catches the one coefficient already in flight.
            if (!stall) begin
                if (skid_vld) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= skid_addr;
                    wr_data  <= skid_data;
                    skid_vld <= 1'b0;
                end else begin
                    wr_en <= rd_vld;
                    if (rd_vld) begin
                        wr_addr <= rd_tag;
                        wr_data <= res;
                    end
                end
            end else if (rd_vld) begin
                skid_vld  <= 1'b1;
                skid_addr <= rd_tag;
                skid_data <= res;
            end
        end
    end

endmodule

// File: tb/tb_ter_poly_ctrl.sv
// Scoreboard bench for ter_poly_ctrl with N=4: directed vectors,
// stall window, error flag, start-while-busy and mid-op reset.
module tb_ter_poly_ctrl;

    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          busy, done, err, rd_en, wr_en, wr_ready;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [1:0]    a_data, b_data, wr_data;

    ter_poly_ctrl #(.N(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .a_data(a_data), .b_data(b_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int stall_lo = -1;
    int stall_hi = -1;
    assign wr_ready = !(cyc >= stall_lo && cyc <= stall_hi);

    logic [1:0] mem_a [N];
    logic [1:0] mem_b [N];
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[rd_addr];
            b_data <= mem_b[rd_addr];
        end else begin
            a_data <= 2'b00;
            b_data <= 2'b00;
        end
    end

    typedef struct {
        int            c;
        logic [AW-1:0] addr;
        logic [1:0]    data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    wr_t e;
    int  dc;
    int  checks = 0;
    int  passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    endtask

    // Monitor: pops the scoreboard on every completed write and done pulse.
    always @(negedge clk) begin
        if (wr_en && wr_ready) begin
            if (wq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write @cyc %0d: addr %0d", cyc, wr_addr);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("wr_cycle", cyc, e.c);
            end
        end
        if (done) begin
            chk("busy_at_done", 32'(busy), 32'd0);
            if (dq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done @cyc %0d: got 1 want 0", cyc);
            end else begin
                dc = dq.pop_front();
                chk("done_cycle", cyc, dc);
            end
        end
        if (!rd_en) chk("rd_addr_idle", 32'(rd_addr), 32'd0);
    end

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
    endtask

    task automatic push_exp(input int s, input logic [1:0] r[N],
                            input bit stl);
        wr_t w;
        for (int i = 0; i < N; i++) begin
            w.c    = s + 3 + i + ((stl && i > 0) ? 3 : 0);
            w.addr = AW'(i);
            w.data = r[i];
            wq.push_back(w);
        end
        dq.push_back(s + N + 3 + (stl ? 3 : 0));
    endtask

    // Called #1 after a posedge; start is presented in the current cycle.
    task automatic run(input logic [1:0] o, input logic [1:0] a[N],
                       input logic [1:0] b[N], input logic [1:0] r[N],
                       input bit stl);
        int s;
        s = cyc;
        for (int i = 0; i < N; i++) begin
            mem_a[i] = a[i];
            mem_b[i] = b[i];
        end
        if (stl) begin
            stall_lo = s + 4;
            stall_hi = s + 6;
        end
        push_exp(s, r, stl);
        start = 1'b1;
        op    = o;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("writes_left", wq.size(), 0);
        chk("dones_left", dq.size(), 0);
        stall_lo = -1;
        stall_hi = -1;
    endtask

    initial begin
        int s;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        outs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run(2'b00, '{2'b01, 2'b01, 2'b11, 2'b00}, '{2'b01, 2'b11, 2'b11, 2'b01},
            '{2'b11, 2'b00, 2'b01, 2'b01}, 1'b0);
        chk("err_clean_add", 32'(err), 0);

        s = cyc;
        fork
            run(2'b00, '{2'b01, 2'b01, 2'b10, 2'b00}, '{2'b01, 2'b11, 2'b11, 2'b01},
                '{2'b11, 2'b00, 2'b11, 2'b01}, 1'b0);
            begin
                at_neg(s + 4);
                chk("err_before", 32'(err), 0);
                at_neg(s + 5);
                chk("err_set", 32'(err), 1);
            end
        join
        chk("err_sticky", 32'(err), 1);

        s = cyc;
        fork
            run(2'b01, '{2'b00, 2'b01, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b01, 2'b01},
                '{2'b11, 2'b11, 2'b01, 2'b00}, 1'b0);
            begin
                at_neg(s);
                chk("err_held_to_start", 32'(err), 1);
                at_neg(s + 1);
                chk("err_cleared", 32'(err), 0);
            end
        join

        run(2'b10, '{2'b00, 2'b01, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b01, 2'b01},
            '{2'b00, 2'b11, 2'b11, 2'b01}, 1'b0);

        run(2'b11, '{2'b00, 2'b01, 2'b11, 2'b01}, '{2'b10, 2'b10, 2'b10, 2'b10},
            '{2'b00, 2'b11, 2'b01, 2'b11}, 1'b0);
        chk("err_neg_ignores_b", 32'(err), 0);

        run(2'b00, '{2'b01, 2'b01, 2'b11, 2'b00}, '{2'b01, 2'b11, 2'b11, 2'b01},
            '{2'b11, 2'b00, 2'b01, 2'b01}, 1'b1);

        s = cyc;
        fork
            run(2'b10, '{2'b00, 2'b01, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b01, 2'b01},
                '{2'b00, 2'b11, 2'b11, 2'b01}, 1'b0);
            begin
                do begin @(posedge clk); #1; end while (cyc < s + 2);
                start = 1'b1;
                op    = 2'b11;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join

        // Mid-operation reset, then a start in the release cycle.
        s = cyc;
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 2'b01;
            mem_b[i] = 2'b01;
        end
        e.c = s + 3; e.addr = 0; e.data = 2'b11; wq.push_back(e);
        e.c = s + 4; e.addr = 1; e.data = 2'b11; wq.push_back(e);
        start = 1'b1;
        op    = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        do begin @(posedge clk); #1; end while (cyc < s + 4);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        outs_zero("midreset");
        chk("writes_before_reset", wq.size(), 0);
        s = cyc;
        run(2'b01, '{2'b00, 2'b01, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b01, 2'b01},
            '{2'b11, 2'b11, 2'b01, 2'b00}, 1'b0);
        chk("restart_ok", wq.size() + dq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
